vga_grid_sampler: RTL and testbench

//  Parametrised VGA timing generator with a configurable GRID_W x GRID_H down-sampling window.

---
 rtl/vga_grid_sampler.sv | 188 ++++++++++++++++++
 tb/tb_vga_grid_sampler.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_grid_sampler.sv
// VGA timing generator with a GRID_W x GRID_H down-sampling window, colour mode select and sample strobes.
// Latency: every registered output reflects the counter position of the previous cycle (1 cycle).
// No backpressure: the raster free-runs, and oRequest runs REQ_LEAD cycles ahead so upstream can keep up.
module vga_grid_sampler #(
    parameter int H_ACT    = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACT    = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int GRID_W   = 28,
    parameter int GRID_H   = 28,
    parameter int STRIDE   = 16,
    parameter int WIN_X0   = 96,
    parameter int WIN_Y0   = 16,
    parameter int DATA_W   = 8,
    parameter int N_MODES  = 3,
    parameter int REQ_LEAD = 2
) (
    input  logic                         iCLK,
    input  logic                         iRST_N,
    input  logic [DATA_W-1:0]            iRed,
    input  logic [DATA_W-1:0]            iGreen,
    input  logic [DATA_W-1:0]            iBlue,
    input  logic [DATA_W-1:0]            iGrey,
    input  logic [DATA_W-1:0]            iBW,
    input  logic                         iMode_step,
    input  logic                         iOverlay_en,
    output logic                         oRequest,
    output logic [DATA_W-1:0]            oVGA_R,
    output logic [DATA_W-1:0]            oVGA_G,
    output logic [DATA_W-1:0]            oVGA_B,
    output logic                         oVGA_H_SYNC,
    output logic                         oVGA_V_SYNC,
    output logic                         oVGA_BLANK,
    output logic                         oVGA_SYNC,
    output logic                         oVGA_CLOCK,
    output logic                         oFrame_start,
    output logic                         oSample_valid,
    output logic [$clog2(GRID_W)-1:0]    oSample_X,
    output logic [$clog2(GRID_H)-1:0]    oSample_Y,
    output logic                         oGrid_done,
    output logic [$clog2(N_MODES)-1:0]   oMode
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_ACT + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACT + V_FP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int XW      = $clog2(GRID_W);
    localparam int YW      = $clog2(GRID_H);
    localparam int MW      = $clog2(N_MODES);
    localparam int SB      = $clog2(STRIDE);
    localparam int H_ACT0  = H_SYNC + H_BP;
    localparam int V_ACT0  = V_SYNC + V_BP;

    // Window and stride must fit the visible area; the stride is used as a mask/shift.
    if (GRID_W * STRIDE + WIN_X0 > H_ACT) begin : gWinXCheck
        $error("vga_grid_sampler: GRID_W*STRIDE+WIN_X0 exceeds H_ACT");
    end
    if (GRID_H * STRIDE + WIN_Y0 > V_ACT) begin : gWinYCheck
        $error("vga_grid_sampler: GRID_H*STRIDE+WIN_Y0 exceeds V_ACT");
    end
    if ((1 << SB) != STRIDE) begin : gStrideCheck
        $error("vga_grid_sampler: STRIDE must be a power of two");
    end

    logic [HW-1:0]     hCont;
    logic [VW-1:0]     vCont;
    int                hPos, vPos, ax, ay, wx, wy;
    logic              active, reqActive, samplePt, frameEdge;
    logic [DATA_W-1:0] nextR, nextG, nextB;
    logic [1:0]        stepSync;
    logic              stepPrev, stepEdge, pending;

    assign oVGA_BLANK = oVGA_H_SYNC & oVGA_V_SYNC;
    assign oVGA_SYNC  = 1'b0;
    assign oVGA_CLOCK = iCLK;
    assign stepEdge   = stepSync[1] & ~stepPrev;

    // Raster counters: H wraps every line, V advances on the H wrap.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            hCont <= '0;
            vCont <= '0;
        end else if (hCont == HW'(H_TOTAL - 1)) begin
            hCont <= '0;
            vCont <= (vCont == VW'(V_TOTAL - 1)) ? '0 : vCont + 1'b1;
        end else begin
            hCont <= hCont + 1'b1;
        end
    end

    // Decode the current raster position into active, request and grid-sample flags.
    always_comb begin
        hPos      = int'(hCont);
        vPos      = int'(vCont);
        ax        = hPos - H_ACT0;
        ay        = vPos - V_ACT0;
        wx        = ax - WIN_X0;
        wy        = ay - WIN_Y0;
        active    = (ax >= 0) && (ax < H_ACT) && (ay >= 0) && (ay < V_ACT);
        reqActive = (hPos + REQ_LEAD >= H_ACT0) && (hPos + REQ_LEAD < H_ACT0 + H_ACT) &&
                    (ay >= 0) && (ay < V_ACT);
        // Indices come straight from the counters, so a glitch can never accumulate drift.
        samplePt  = (wx >= 0) && (wx < GRID_W * STRIDE) &&
                    (wy >= 0) && (wy < GRID_H * STRIDE) &&
                    ((wx & (STRIDE - 1)) == 0) && ((wy & (STRIDE - 1)) == 0);
        frameEdge = (hCont == '0) && (vCont == '0);
    end

    // Colour select: sample points may be forced to the thresholded pixel, blanking is black.
    always_comb begin
        nextR = '0;
        nextG = '0;
        nextB = '0;
        if (active) begin
            if (samplePt && (iOverlay_en || oMode == MW'(2))) begin
                nextR = iBW;
                nextG = iBW;
                nextB = iBW;
            end else if (oMode == MW'(1)) begin
                nextR = iGrey;
                nextG = iGrey;
                nextB = iGrey;
            end else if (oMode == MW'(2)) begin
                nextR = iBW;
                nextG = iBW;
                nextB = iBW;
            end else begin
                nextR = iRed;
                nextG = iGreen;
                nextB = iBlue;
            end
        end
    end

    // Register every DAC/strobe output so all of them share the same one-cycle latency.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            oRequest      <= 1'b0;
            oVGA_H_SYNC   <= 1'b0;
            oVGA_V_SYNC   <= 1'b0;
            oVGA_R        <= '0;
            oVGA_G        <= '0;
            oVGA_B        <= '0;
            oFrame_start  <= 1'b0;
            oSample_valid <= 1'b0;
            oSample_X     <= '0;
            oSample_Y     <= '0;
            oGrid_done    <= 1'b0;
        end else begin
            oRequest      <= reqActive;
            oVGA_H_SYNC   <= (hPos >= H_SYNC);
            oVGA_V_SYNC   <= (vPos >= V_SYNC);
            oVGA_R        <= nextR;
            oVGA_G        <= nextG;
            oVGA_B        <= nextB;
            oFrame_start  <= frameEdge;
            oSample_valid <= samplePt;
            oSample_X     <= samplePt ? XW'(wx >> SB) : '0;
            oSample_Y     <= samplePt ? YW'(wy >> SB) : '0;
            oGrid_done    <= samplePt && ((wx >> SB) == GRID_W - 1) && ((wy >> SB) == GRID_H - 1);
        end
    end

    // Key edges arm a pending step that is only applied on the frame boundary.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            stepSync <= '0;
            stepPrev <= 1'b0;
            pending  <= 1'b0;
            oMode    <= '0;
        end else begin
            stepSync <= {stepSync[0], iMode_step};
            stepPrev <= stepSync[1];
            if (frameEdge && pending) begin
                pending <= 1'b0;
                oMode   <= (oMode == MW'(N_MODES - 1)) ? '0 : oMode + 1'b1;
            end else if (stepEdge) begin
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vga_grid_sampler.sv
// Directed bench for vga_grid_sampler on a reduced raster (80x55, 4x3 grid, stride 8).
// Outputs are sampled 1 time unit after each rising edge; expected values are hand-computed.
// The raster never stalls; every wait is bounded by slightly more than one frame.
module tb_vga_grid_sampler;

    localparam int FRAME = 80 * 55;

    logic       iCLK, iRST_N;
    logic [7:0] iRed, iGreen, iBlue, iGrey, iBW;
    logic       iMode_step, iOverlay_en;
    logic       oRequest;
    logic [7:0] oVGA_R, oVGA_G, oVGA_B;
    logic       oVGA_H_SYNC, oVGA_V_SYNC, oVGA_BLANK, oVGA_SYNC, oVGA_CLOCK;
    logic       oFrame_start, oSample_valid, oGrid_done;
    logic [1:0] oSample_X, oSample_Y, oMode;

    int tests = 0;
    int fails = 0;
    int n     = 0;

    int hsLow, vsLow, blankLow, reqCnt, fsCnt, fs1, fs2, sCnt, gdCnt;
    int firstS, lastS, firstReq, firstVis, rgbAtSample, ffAtSample, redCnt, chg;
    logic [1:0] fx, fy, lx, ly, cur;
    logic [1:0] expMode [3] = '{2'd2, 2'd0, 2'd1};
    logic [7:0] expR    [3] = '{8'hFF, 8'h11, 8'h44};
    logic [7:0] expG    [3] = '{8'hFF, 8'h22, 8'h44};
    logic [7:0] expB    [3] = '{8'hFF, 8'h33, 8'h44};

    vga_grid_sampler #(
        .H_ACT(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACT(48), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .GRID_W(4), .GRID_H(3), .STRIDE(8), .WIN_X0(16), .WIN_Y0(8),
        .DATA_W(8), .N_MODES(3), .REQ_LEAD(2)
    ) dut (
        .iCLK(iCLK), .iRST_N(iRST_N),
        .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue), .iGrey(iGrey), .iBW(iBW),
        .iMode_step(iMode_step), .iOverlay_en(iOverlay_en),
        .oRequest(oRequest),
        .oVGA_R(oVGA_R), .oVGA_G(oVGA_G), .oVGA_B(oVGA_B),
        .oVGA_H_SYNC(oVGA_H_SYNC), .oVGA_V_SYNC(oVGA_V_SYNC),
        .oVGA_BLANK(oVGA_BLANK), .oVGA_SYNC(oVGA_SYNC), .oVGA_CLOCK(oVGA_CLOCK),
        .oFrame_start(oFrame_start), .oSample_valid(oSample_valid),
        .oSample_X(oSample_X), .oSample_Y(oSample_Y),
        .oGrid_done(oGrid_done), .oMode(oMode)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge iCLK);
        #1;
        n++;
    endtask

    // Advance until the outputs show raster position st (frame cycle index).
    task automatic wait_state(input int st);
        int k;
        k = 0;
        while (((n - 1) % FRAME) != st && k < FRAME + 5) begin
            tick();
            k++;
        end
        check("wait_state_bound", 32'(k < FRAME + 5), 32'd1);
    endtask

    // Advance to the next oFrame_start, counting cycles where oMode left `hold` before it.
    task automatic wait_frame(input logic [1:0] hold, output int changes);
        int k;
        k = 0;
        changes = 0;
        do begin
            tick();
            k++;
            if (!oFrame_start && oMode !== hold) changes++;
        end while (!oFrame_start && k < FRAME + 5);
        check("wait_frame_bound", 32'(oFrame_start), 32'd1);
    endtask

    task automatic pulse_step();
        iMode_step = 1'b1;
        repeat (4) tick();
        iMode_step = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        iRST_N = 1'b0; iMode_step = 1'b0; iOverlay_en = 1'b0;
        iRed = 8'h11; iGreen = 8'h22; iBlue = 8'h33; iGrey = 8'h44; iBW = 8'hFF;
        repeat (3) @(posedge iCLK);
        #1;
        // Reset state
        check("rst_req",   32'(oRequest), 0);
        check("rst_hs",    32'(oVGA_H_SYNC), 0);
        check("rst_vs",    32'(oVGA_V_SYNC), 0);
        check("rst_blank", 32'(oVGA_BLANK), 0);
        check("rst_sync",  32'(oVGA_SYNC), 0);
        check("rst_rgb",   {8'h0, oVGA_R, oVGA_G, oVGA_B}, 0);
        check("rst_fs",    32'(oFrame_start), 0);
        check("rst_sv",    {28'h0, oSample_X, oSample_Y} | 32'(oSample_valid) | 32'(oGrid_done), 0);
        check("rst_mode",  32'(oMode), 0);
        @(negedge iCLK);
        iRST_N = 1'b1;
        n = 0;

        // Two frames of timing, mode 0 without overlay
        hsLow = 0; vsLow = 0; blankLow = 0; reqCnt = 0; fsCnt = 0; fs1 = 0; fs2 = 0;
        sCnt = 0; gdCnt = 0; firstS = 0; lastS = 0; firstReq = 0; firstVis = 0; rgbAtSample = 0;
        fx = '0; fy = '0; lx = '0; ly = '0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick();
            if (!oVGA_H_SYNC) hsLow++;
            if (!oVGA_V_SYNC) vsLow++;
            if (!oVGA_BLANK)  blankLow++;
            if (oRequest) begin
                reqCnt++;
                if (firstReq == 0) firstReq = n;
            end
            if (oVGA_R != 8'h00 && firstVis == 0) firstVis = n;
            if (oFrame_start) begin
                fsCnt++;
                if (fsCnt == 1) fs1 = n;
                else fs2 = n;
            end
            if (oSample_valid) begin
                sCnt++;
                if ({oVGA_R, oVGA_G, oVGA_B} == 24'h112233) rgbAtSample++;
                if (sCnt == 1) begin
                    firstS = n; fx = oSample_X; fy = oSample_Y;
                end
                if (oGrid_done && gdCnt == 0) begin
                    lastS = n; lx = oSample_X; ly = oSample_Y;
                end
            end
            if (oGrid_done) gdCnt++;
        end
        check("hs_low_cycles",    hsLow, 880);
        check("vs_low_cycles",    vsLow, 320);
        check("blank_low_cycles", blankLow, 1168);
        check("request_cycles",   reqCnt, 6144);
        check("frame_start_cnt",  fsCnt, 2);
        check("frame_start_1",    fs1, 1);
        check("frame_start_2",    fs2, 4401);
        check("sample_cnt",       sCnt, 24);
        check("grid_done_cnt",    gdCnt, 2);
        check("first_sample_at",  firstS, 1069);
        check("first_sample_xy",  {fx, fy}, 0);
        check("last_sample_at",   lastS, 2373);
        check("last_sample_xy",   {lx, ly}, {2'd3, 2'd2});
        check("first_request_at", firstReq, 411);
        check("first_visible_at", firstVis, 413);
        check("request_lead",     firstVis - firstReq, 2);
        check("rgb_at_samples",   rgbAtSample, 24);

        // Two key presses mid-frame: one step, applied only at the next frame start
        wait_state(2000);
        pulse_step();
        pulse_step();
        wait_frame(2'd0, chg);
        check("mode_no_midframe_change", chg, 0);
        check("mode_after_boundary", 32'(oMode), 1);
        check("mode_boundary_at", (n - 1) % FRAME, 0);
        wait_frame(2'd1, chg);
        check("second_press_ignored", {chg[29:0], oMode}, 1);

        // Three steps in three frames: 2, 0 (wrap), 1 with matching colour
        cur = 2'd1;
        for (int i = 0; i < 3; i++) begin
            wait_state(1000);
            pulse_step();
            wait_frame(cur, chg);
            check("step_no_midframe_change", chg, 0);
            check("step_mode", 32'(oMode), 32'(expMode[i]));
            cur = expMode[i];
            wait_state(500);
            check("step_colour", {8'h0, oVGA_R, oVGA_G, oVGA_B}, {8'h0, expR[i], expG[i], expB[i]});
        end

        // Asynchronous reset in the middle of a line
        wait_state(1070);
        #3;
        iRST_N = 1'b0;
        #1;
        check("arst_outputs", {oRequest, oVGA_H_SYNC, oVGA_V_SYNC, oFrame_start,
                               oSample_valid, oGrid_done, oMode, oSample_X, oSample_Y}, 0);
        check("arst_rgb", {8'h0, oVGA_R, oVGA_G, oVGA_B}, 0);
        repeat (2) @(posedge iCLK);
        #1;
        check("arst_held", {oRequest, oVGA_H_SYNC, oVGA_V_SYNC, oFrame_start, oMode}, 0);
        iOverlay_en = 1'b1;
        @(negedge iCLK);
        iRST_N = 1'b1;
        n = 0;

        // One frame in mode 0 with overlay: grid restarts, sample pixels show iBW
        sCnt = 0; gdCnt = 0; firstS = 0; lastS = 0; ffAtSample = 0; redCnt = 0; fs1 = 0;
        fx = 2'd3; fy = 2'd3; lx = '0; ly = '0;
        for (int i = 0; i < FRAME; i++) begin
            tick();
            if (oFrame_start && fs1 == 0) fs1 = n;
            if (oSample_valid) begin
                sCnt++;
                if ({oVGA_R, oVGA_G, oVGA_B} == 24'hFFFFFF) ffAtSample++;
                if (sCnt == 1) begin
                    firstS = n; fx = oSample_X; fy = oSample_Y;
                end
            end else if (oVGA_R == 8'h11) begin
                redCnt++;
            end
            if (oGrid_done) begin
                gdCnt++;
                lastS = n; lx = oSample_X; ly = oSample_Y;
            end
        end
        check("post_rst_frame_start", fs1, 1);
        check("post_rst_mode", 32'(oMode), 0);
        check("post_rst_first_at", firstS, 1069);
        check("post_rst_first_xy", {fx, fy}, 0);
        check("post_rst_samples", sCnt, 12);
        check("post_rst_grid_done", gdCnt, 1);
        check("post_rst_last", {lastS[29:0], lx, ly}, {30'd2373, 2'd3, 2'd2});
        check("overlay_sample_ff", ffAtSample, 12);
        check("overlay_other_red", redCnt, 3060);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
